// File: rtl/wb_write_queue.sv
// ---------------------------------------------------------------------------
// wb_write_queue
// In-order write-back queue in front of the register file write port.
// Collects write-back requests from the ALU and load pipes, drains one entry
// per cycle onto we3/wa3/wd3, and can forward not-yet-written data to the
// two read ports.
//
// Build option:
//   WBQ_FWD_EN  defined   -> read-port forwarding lookup is built
//               undefined -> fwd*_hit / fwd*_data tied to 0
//
// Ports:
//   clk, reset_n                clock, asynchronous active-low reset
//   alu_valid/alu_rd/alu_data   ALU write-back request
//   mem_valid/mem_rd/mem_data   load write-back request
//   in_ready                    room for both producers this cycle
//   we3/wa3/wd3                 register file write port (head entry)
//   ra1/ra2                     register file read addresses
//   fwd1_hit/fwd1_data          youngest pending write matching ra1
//   fwd2_hit/fwd2_data          youngest pending write matching ra2
//   count                       occupied entries
// ---------------------------------------------------------------------------
module wb_write_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 5,
  parameter int unsigned DW    = 64
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   alu_valid,
  input  logic [AW-1:0]          alu_rd,
  input  logic [DW-1:0]          alu_data,
  input  logic                   mem_valid,
  input  logic [AW-1:0]          mem_rd,
  input  logic [DW-1:0]          mem_data,
  output logic                   in_ready,
  output logic                   we3,
  output logic [AW-1:0]          wa3,
  output logic [DW-1:0]          wd3,
  input  logic [AW-1:0]          ra1,
  input  logic [AW-1:0]          ra2,
  output logic                   fwd1_hit,
  output logic [DW-1:0]          fwd1_data,
  output logic                   fwd2_hit,
  output logic [DW-1:0]          fwd2_data,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [AW-1:0] XZR = AW'(31);

  logic [AW-1:0] r_rd   [DEPTH];
  logic [DW-1:0] r_data [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic          w_in_ready;
  logic          w_pop;
  logic          w_mem_push;
  logic          w_alu_push;
  logic [PW-1:0] w_alu_idx;
  logic [CW-1:0] w_count_next;

  // Accept only when both producers could be absorbed at once.
  assign w_in_ready = (r_count <= CW'(DEPTH - 2));
  assign w_pop      = (r_count != '0);

  // Writes to XZR are discarded at the door and never take a slot.
  assign w_mem_push = w_in_ready & mem_valid & (mem_rd != XZR);
  assign w_alu_push = w_in_ready & alu_valid & (alu_rd != XZR);

  // Load entry is older, so the ALU entry lands behind it when both push.
  assign w_alu_idx    = r_wr_ptr + PW'(w_mem_push);
  assign w_count_next = r_count + CW'(w_mem_push) + CW'(w_alu_push) - CW'(w_pop);

  // Queue storage, pointers and occupancy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_rd[i]   <= '0;
        r_data[i] <= '0;
      end
    end else begin
      if (w_mem_push) begin
        r_rd[r_wr_ptr]   <= mem_rd;
        r_data[r_wr_ptr] <= mem_data;
      end
      if (w_alu_push) begin
        r_rd[w_alu_idx]   <= alu_rd;
        r_data[w_alu_idx] <= alu_data;
      end
      r_wr_ptr <= r_wr_ptr + PW'(w_mem_push) + PW'(w_alu_push);
      r_rd_ptr <= r_rd_ptr + PW'(w_pop);
      r_count  <= w_count_next;
    end
  end

  // Head entry presented to the register file; zeros when empty.
  always_comb begin
    we3 = 1'b0;
    wa3 = '0;
    wd3 = '0;
    if (w_pop) begin
      we3 = 1'b1;
      wa3 = r_rd[r_rd_ptr];
      wd3 = r_data[r_rd_ptr];
    end
  end

  assign in_ready = w_in_ready;
  assign count    = r_count;

`ifdef WBQ_FWD_EN
  // Scan oldest to youngest so the last match seen is the youngest.
  for (genvar p = 0; p < 2; p++) begin : g_fwd
    logic [AW-1:0] w_ra;
    logic          w_hit;
    logic [DW-1:0] w_fdata;

    assign w_ra = (p == 0) ? ra1 : ra2;

    always_comb begin
      w_hit   = 1'b0;
      w_fdata = '0;
      for (int unsigned k = 0; k < DEPTH; k++) begin
        if ((CW'(k) < r_count) && (w_ra != XZR) &&
            (r_rd[r_rd_ptr + PW'(k)] == w_ra)) begin
          w_hit   = 1'b1;
          w_fdata = r_data[r_rd_ptr + PW'(k)];
        end
      end
    end
  end

  assign fwd1_hit  = g_fwd[0].w_hit;
  assign fwd1_data = g_fwd[0].w_fdata;
  assign fwd2_hit  = g_fwd[1].w_hit;
  assign fwd2_data = g_fwd[1].w_fdata;
`else
  logic w_unused_ra;

  assign w_unused_ra = ^{ra1, ra2};
  assign fwd1_hit    = 1'b0;
  assign fwd1_data   = '0;
  assign fwd2_hit    = 1'b0;
  assign fwd2_data   = '0;
`endif

endmodule

// File: tb/tb_wb_write_queue.sv
// ---------------------------------------------------------------------------
// tb_wb_write_queue
// Scoreboard bench for wb_write_queue. The stimulus side drives producers
// (holding a request until the reference queue says it was taken) and pushes
// every accepted write into an expected-write queue; a negedge monitor pops
// that queue whenever the DUT asserts we3 and checks occupancy, in_ready,
// empty-port zeros and forwarding against the reference queue.
// ---------------------------------------------------------------------------
module tb_wb_write_queue;

  localparam int DEPTH = 4;

  typedef struct {
    logic [4:0]  rd;
    logic [63:0] data;
  } ent_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        alu_valid = 1'b0;
  logic [4:0]  alu_rd = '0;
  logic [63:0] alu_data = '0;
  logic        mem_valid = 1'b0;
  logic [4:0]  mem_rd = '0;
  logic [63:0] mem_data = '0;
  logic        in_ready;
  logic        we3;
  logic [4:0]  wa3;
  logic [63:0] wd3;
  logic [4:0]  ra1 = '0;
  logic [4:0]  ra2 = '0;
  logic        fwd1_hit;
  logic [63:0] fwd1_data;
  logic        fwd2_hit;
  logic [63:0] fwd2_data;
  logic [2:0]  count;

  int n_checks = 0;
  int n_fail   = 0;

  ent_t pend[$];     // reference queue contents
  ent_t exp_wr[$];   // scoreboard of writes still to be seen on we3
  int   msz;

  wb_write_queue #(.DEPTH(DEPTH), .AW(5), .DW(64)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .alu_valid (alu_valid),
    .alu_rd    (alu_rd),
    .alu_data  (alu_data),
    .mem_valid (mem_valid),
    .mem_rd    (mem_rd),
    .mem_data  (mem_data),
    .in_ready  (in_ready),
    .we3       (we3),
    .wa3       (wa3),
    .wd3       (wd3),
    .ra1       (ra1),
    .ra2       (ra2),
    .fwd1_hit  (fwd1_hit),
    .fwd1_data (fwd1_data),
    .fwd2_hit  (fwd2_hit),
    .fwd2_data (fwd2_data),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit model_ready();
    return (DEPTH - pend.size()) >= 2;
  endfunction

  // Youngest pending write to ra; forwarding exists only in the option build.
  function automatic void fwd_model(input logic [4:0] ra, output logic hit,
                                    output logic [63:0] d);
    hit = 1'b0;
    d   = '0;
`ifdef WBQ_FWD_EN
    if (ra != 5'd31)
      foreach (pend[i])
        if (pend[i].rd == ra) begin
          hit = 1'b1;
          d   = pend[i].data;
        end
`endif
  endfunction

  // Reference queue: one retire per edge when non-empty, then accepted pushes.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend.delete();
      exp_wr.delete();
    end else begin
      msz = pend.size();
      if (msz != 0) void'(pend.pop_front());
      if ((DEPTH - msz) >= 2) begin
        if (mem_valid && mem_rd != 5'd31) begin
          pend.push_back('{mem_rd, mem_data});
          exp_wr.push_back('{mem_rd, mem_data});
        end
        if (alu_valid && alu_rd != 5'd31) begin
          pend.push_back('{alu_rd, alu_data});
          exp_wr.push_back('{alu_rd, alu_data});
        end
      end
    end
  end

  // Monitor: compare on the falling edge, away from input changes.
  always @(negedge clk) begin
    logic        h;
    logic [63:0] d;
    ent_t        e;
    if (reset_n) begin
      chk("count", 64'(count), 64'(pend.size()));
      chk("in_ready", 64'(in_ready), 64'(model_ready()));
      chk("we3", 64'(we3), 64'(pend.size() != 0));
      if (we3) begin
        if (exp_wr.size() == 0) begin
          chk("unexpected_write", 64'(we3), 64'd0);
        end else begin
          e = exp_wr.pop_front();
          chk("wa3", 64'(wa3), 64'(e.rd));
          chk("wd3", wd3, e.data);
        end
      end else begin
        chk("wa3_idle", 64'(wa3), 64'd0);
        chk("wd3_idle", wd3, 64'd0);
      end
      fwd_model(ra1, h, d);
      chk("fwd1_hit", 64'(fwd1_hit), 64'(h));
      chk("fwd1_data", fwd1_data, d);
      fwd_model(ra2, h, d);
      chk("fwd2_hit", 64'(fwd2_hit), 64'(h));
      chk("fwd2_data", fwd2_data, d);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request pair and hold it until the reference queue accepts it.
  task automatic issue(input logic mv, input logic [4:0] mrd, input logic [63:0] md,
                       input logic av, input logic [4:0] ard, input logic [63:0] ad);
    int tries;
    bit acc;
    tries     = 0;
    mem_valid = mv;
    mem_rd    = mrd;
    mem_data  = md;
    alu_valid = av;
    alu_rd    = ard;
    alu_data  = ad;
    forever begin
      acc = model_ready();
      step();
      if (acc || !(mv || av)) break;
      tries++;
      if (tries > 20) begin
        chk("hold_timeout", 64'(tries), 64'd0);
        break;
      end
    end
    mem_valid = 1'b0;
    alu_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (pend.size() != 0 && t < 20) begin
      step();
      t++;
    end
    chk("drain_timeout", 64'(pend.size()), 64'd0);
  endtask

  function automatic logic [4:0] rnd_rd();
    int r;
    r = $urandom_range(0, 8);
    return (r == 8) ? 5'd31 : 5'(r);
  endfunction

  initial begin
    logic        eh1;
    logic [63:0] ed1;

    // Reset values.
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_we3", 64'(we3), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_wa3", 64'(wa3), 64'd0);
    chk("rst_wd3", wd3, 64'd0);
    chk("rst_fwd1", 64'(fwd1_hit), 64'd0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    step();

    // Single ALU write falls through in one cycle.
    issue(1'b0, 5'd0, 64'd0, 1'b1, 5'd5, 64'hAA);
    chk("t2_we3", 64'(we3), 64'd1);
    chk("t2_wa3", 64'(wa3), 64'd5);
    chk("t2_wd3", wd3, 64'hAA);
    step();
    chk("t2_we3_off", 64'(we3), 64'd0);

    // Simultaneous producers: load first, ALU second.
    issue(1'b1, 5'd3, 64'h11, 1'b1, 5'd4, 64'h22);
    chk("t3_wa3_a", 64'(wa3), 64'd3);
    chk("t3_wd3_a", wd3, 64'h11);
    step();
    chk("t3_wa3_b", 64'(wa3), 64'd4);
    chk("t3_wd3_b", wd3, 64'h22);
    step();
    chk("t3_we3_off", 64'(we3), 64'd0);

    // Write to XZR is dropped.
    issue(1'b0, 5'd0, 64'd0, 1'b1, 5'd31, 64'hFF);
    chk("t4_count", 64'(count), 64'd0);
    chk("t4_we3", 64'(we3), 64'd0);

    // Fill to DEPTH-1 and hold a request across the not-ready window.
    issue(1'b1, 5'd1, 64'h101, 1'b1, 5'd2, 64'h102);
    chk("t5_count2", 64'(count), 64'd2);
    issue(1'b1, 5'd3, 64'h103, 1'b1, 5'd4, 64'h104);
    chk("t5_count3", 64'(count), 64'd3);
    chk("t5_not_ready", 64'(in_ready), 64'd0);
    issue(1'b0, 5'd0, 64'd0, 1'b1, 5'd9, 64'h109);
    drain();

    // Reset while draining with three entries pending.
    issue(1'b1, 5'd10, 64'h201, 1'b1, 5'd11, 64'h202);
    issue(1'b1, 5'd12, 64'h203, 1'b1, 5'd13, 64'h204);
    chk("t1_count3", 64'(count), 64'd3);
    #2 reset_n = 1'b0;
    #1;
    chk("t1_we3", 64'(we3), 64'd0);
    chk("t1_count", 64'(count), 64'd0);
    chk("t1_in_ready", 64'(in_ready), 64'd1);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (3) step();
    chk("t1_no_writes", 64'(we3), 64'd0);

    // Forwarding: two pending writes to x7, the younger must win.
    ra1 = 5'd7;
    ra2 = 5'd31;
    issue(1'b1, 5'd7, 64'd1, 1'b1, 5'd7, 64'd2);
    fwd_model(5'd7, eh1, ed1);
`ifdef WBQ_FWD_EN
    chk("t6_fwd1_hit", 64'(fwd1_hit), 64'd1);
    chk("t6_fwd1_data", fwd1_data, 64'd2);
`else
    chk("t6_fwd1_hit", 64'(fwd1_hit), 64'd0);
    chk("t6_fwd1_data", fwd1_data, 64'd0);
`endif
    chk("t6_fwd1_model", 64'(fwd1_hit), 64'(eh1));
    chk("t6_fwd2_hit", 64'(fwd2_hit), 64'd0);
    drain();

    // Randomized traffic against the reference queue.
    for (int n = 0; n < 400; n++) begin
      logic        mv, av;
      logic [4:0]  mrd, ard;
      logic [63:0] md, ad;
      mv  = ($urandom_range(0, 1) == 1);
      av  = ($urandom_range(0, 1) == 1);
      mrd = rnd_rd();
      ard = rnd_rd();
      md  = {$urandom, $urandom};
      ad  = {$urandom, $urandom};
      ra1 = rnd_rd();
      ra2 = rnd_rd();
      issue(mv, mrd, md, av, ard, ad);
    end
    drain();
    step();
    chk("end_scoreboard_empty", 64'(exp_wr.size()), 64'd0);
    chk("end_count", 64'(count), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
